// File: rtl/seg7_scan_mux_pkg.sv
// +----------------------------------------------------------------------+
// | seg7_scan_mux_pkg: shared segment encodings for the 7-seg scan mux.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg7_scan_mux_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low a..g patterns indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

`default_nettype wire

// File: rtl/seg7_scan_mux_hex_to_seg7.sv
// +----------------------------------------------------------------------+
// | hex_to_seg7: combinational hex nibble to active-low a..g pattern.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hex_to_seg7
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_TABLE[hex];
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux.sv
// +----------------------------------------------------------------------+
// | seg7_scan_mux: 8-digit common-anode scan driver with tear-free,      |
// | frame-aligned load/ack commit. Rev 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int DIV        = 100000,
  parameter int NUM_DIGITS = 8
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      load,
  output logic                      load_ack,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_pending;
  logic [4*NUM_DIGITS-1:0]   r_pend_digits;
  logic [NUM_DIGITS-1:0]     r_pend_dp;
  logic [NUM_DIGITS-1:0]     r_pend_blank;
  logic [4*NUM_DIGITS-1:0]   r_act_digits;
  logic [NUM_DIGITS-1:0]     r_act_dp;
  logic [NUM_DIGITS-1:0]     r_act_blank;

  logic                      w_tick;
  logic                      w_frame;
  logic                      w_commit;
  logic [IDX_W-1:0]          w_nxt_idx;
  logic [4*NUM_DIGITS-1:0]   w_nxt_digits;
  logic [NUM_DIGITS-1:0]     w_nxt_dp;
  logic [NUM_DIGITS-1:0]     w_nxt_blank;
  logic [3:0]                w_nibble;
  logic [6:0]                w_dec;
  logic [7:0]                w_seg_nxt;
  logic [NUM_DIGITS-1:0]     w_an_nxt;

  assign w_tick   = (r_cnt == CNT_W'(DIV - 1));
  assign w_frame  = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_commit = w_frame && (load || r_pending);

  always_comb begin
    w_nxt_idx = r_idx;
    if (w_tick) begin
      w_nxt_idx = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // A load landing on the commit edge wins over the buffer (last load wins).
  always_comb begin
    w_nxt_digits = r_act_digits;
    w_nxt_dp     = r_act_dp;
    w_nxt_blank  = r_act_blank;
    if (w_frame && load) begin
      w_nxt_digits = digits_in;
      w_nxt_dp     = dp_in;
      w_nxt_blank  = blank_in;
    end else if (w_frame && r_pending) begin
      w_nxt_digits = r_pend_digits;
      w_nxt_dp     = r_pend_dp;
      w_nxt_blank  = r_pend_blank;
    end
  end

  assign w_nibble = w_nxt_digits[{w_nxt_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (w_nibble),
    .seg_n (w_dec)
  );

  always_comb begin
    w_seg_nxt              = SEG_OFF;
    w_an_nxt               = AN_OFF;
    if (!w_nxt_blank[w_nxt_idx]) begin
      w_seg_nxt[SEG_A:SEG_G] = w_dec;
      w_seg_nxt[SEG_DP]      = ~w_nxt_dp[w_nxt_idx];
      w_an_nxt               = ~(NUM_DIGITS'(1) << w_nxt_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
      r_act_blank   <= '1;
      seg           <= SEG_OFF;
      an            <= AN_OFF;
      load_ack      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_idx        <= w_nxt_idx;
      r_act_digits <= w_nxt_digits;
      r_act_dp     <= w_nxt_dp;
      r_act_blank  <= w_nxt_blank;
      seg          <= w_seg_nxt;
      an           <= w_an_nxt;
      frame_done   <= w_frame;
      load_ack     <= w_commit;
      if (w_frame) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending     <= 1'b1;
        r_pend_digits <= digits_in;
        r_pend_dp     <= dp_in;
        r_pend_blank  <= blank_in;
      end
    end
  end

endmodule

`default_nettype wire
